bibuf_port_ctrl: RTL and testbench

Half-duplex controller for a bank of bidirectional pads. It drives the pad output and output-enable lines of a bidirectional buffer array and samples the returning pad input. It turns core-side read/write requests, using valid/ready handshakes, into safely sequenced pad activity, with programmable turnaround dead cycles and input synchronisation. It sits between portal logic and the pad buffer generate array.

---
 rtl/bibuf_pkg.sv | 19 +
 rtl/bibuf_port_ctrl_if.sv | 24 ++
 rtl/bibuf_sync2.sv | 23 ++
 rtl/bibuf_port_ctrl.sv | 159 +++++++++++++++
 tb/tb_bibuf_port_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bibuf_pkg.sv
// Shared types and constants for the bidirectional pad port controller.
package bibuf_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TURN  = 3'd1,
      S_DRIVE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bibuf_port_ctrl_if.sv
// Core-side request/response handshake bundle for bibuf_port_ctrl.
interface bibuf_port_ctrl_if #(
   parameter int unsigned SIZE = 1
) ();

   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [SIZE-1:0] req_data;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [SIZE-1:0] rsp_data;

   modport master (
      output req_valid, req_write, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/bibuf_sync2.sv
// Two-flop synchroniser for the asynchronous pad input bus.
module bibuf_sync2 #(
   parameter int unsigned SIZE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] q
);

   logic [SIZE-1:0] meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/bibuf_port_ctrl.sv
// Half-duplex pad bank controller: sequences drive/release of a bidirectional
// buffer array with turnaround dead cycles and synchronised read capture.
module bibuf_port_ctrl
   import bibuf_pkg::*;
#(
   parameter int unsigned SIZE   = 1,
   parameter int unsigned TURN   = 1,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   bibuf_port_ctrl_if.slave  bus,
   output logic [SIZE-1:0]   pad_o,
   output logic              pad_oe,
   input  logic [SIZE-1:0]   pad_i
);

   localparam int unsigned   CW        = $clog2(max_u(TURN, RD_LAT) + 1);
   localparam logic [CW-1:0] TURN_LAST = CW'((TURN > 0) ? TURN - 1 : 0);
   localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dir_q, dir_d;
   logic            wr_q, wr_d;
   logic [SIZE-1:0] wdata_q, wdata_d;
   logic [SIZE-1:0] pad_o_q, pad_o_d;
   logic            pad_oe_q, pad_oe_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [SIZE-1:0] rsp_data_q, rsp_data_d;
   logic            req_ready_q, req_ready_d;
   logic [SIZE-1:0] pad_sync;
   logic            req_acc;
   logic            rsp_acc;

   bibuf_sync2 #(.SIZE(SIZE)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_i),
      .q     (pad_sync)
   );

   assign req_acc       = bus.req_valid && req_ready_q;
   assign rsp_acc       = rsp_valid_q && bus.rsp_ready;
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign pad_o         = pad_o_q;
   assign pad_oe        = pad_oe_q;

   // State and dead-cycle/latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a turnaround is needed only when the bus changes direction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_acc) begin
               cnt_d = '0;
               if (bus.req_write)
                  state_d = (dir_q == DIR_OUT || TURN == 0) ? S_DRIVE : S_TURN;
               else
                  state_d = (dir_q == DIR_OUT && TURN != 0) ? S_TURN : S_WAIT;
            end
         end
         S_TURN: begin
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = wr_q ? S_DRIVE : S_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRIVE: state_d = S_IDLE;
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: if (rsp_acc) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output next values; a read accept releases the bus on its own edge
   always_comb begin
      pad_o_d     = pad_o_q;
      pad_oe_d    = pad_oe_q;
      dir_d       = dir_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         S_IDLE: begin
            if (req_acc) begin
               wr_d    = bus.req_write;
               wdata_d = bus.req_data;
               if (!bus.req_write) begin
                  pad_oe_d = 1'b0;
                  pad_o_d  = '0;
                  dir_d    = DIR_IN;
               end
            end
         end
         S_DRIVE: begin
            pad_o_d  = wdata_q;
            pad_oe_d = 1'b1;
            dir_d    = DIR_OUT;
         end
         S_RESP: begin
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = pad_sync;
            end else if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_o_q     <= '0;
         pad_oe_q    <= 1'b0;
         dir_q       <= DIR_IN;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         req_ready_q <= 1'b0;
      end else begin
         pad_o_q     <= pad_o_d;
         pad_oe_q    <= pad_oe_d;
         dir_q       <= dir_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         req_ready_q <= req_ready_d;
      end
   end

endmodule

// File: tb/tb_bibuf_port_ctrl.sv
// Directed bench for bibuf_port_ctrl: TURN=1 and TURN=0 instances, queue scoreboard.
module tb_bibuf_port_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pad_o1, pad_i1, pad_o0, pad_i0;
   logic       pad_oe1, pad_oe0;

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0] wq[$];
   logic [7:0] rq[$];
   logic [7:0] e;

   always #5 clk = ~clk;

   bibuf_port_ctrl_if #(.SIZE(8)) b1 ();
   bibuf_port_ctrl_if #(.SIZE(8)) b0 ();

   bibuf_port_ctrl #(.SIZE(8), .TURN(1), .RD_LAT(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1),
      .pad_o(pad_o1), .pad_oe(pad_oe1), .pad_i(pad_i1)
   );

   bibuf_port_ctrl #(.SIZE(8), .TURN(0), .RD_LAT(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0),
      .pad_o(pad_o0), .pad_oe(pad_oe0), .pad_i(pad_i0)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request into dut1 through its accept edge
   task automatic send1(input logic wr, input logic [7:0] d);
      chk1("dut1_ready_before_accept", b1.req_ready, 1'b1);
      b1.req_valid = 1'b1;
      b1.req_write = wr;
      b1.req_data  = d;
      tick();
      b1.req_valid = 1'b0;
   endtask

   // Output enable must be low in the cycle after a read accept and the one following
   logic rd_prev1 = 1'b0;
   logic rd_prev0 = 1'b0;
   always @(posedge clk) begin
      logic acc;
      acc = rst_n && b1.req_valid && b1.req_ready && !b1.req_write;
      #1;
      if (acc || rd_prev1) chk1("mon1_oe_after_read_accept", pad_oe1, 1'b0);
      rd_prev1 = acc;
   end
   always @(posedge clk) begin
      logic acc;
      acc = rst_n && b0.req_valid && b0.req_ready && !b0.req_write;
      #1;
      if (acc || rd_prev0) chk1("mon0_oe_after_read_accept", pad_oe0, 1'b0);
      rd_prev0 = acc;
   end

   initial begin
      rst_n = 1'b0;
      b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_data = '0; b1.rsp_ready = 1'b0;
      b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_data = '0; b0.rsp_ready = 1'b0;
      pad_i1 = '0;
      pad_i0 = '0;
      #2;
      chk1("reset_oe", pad_oe1, 1'b0);
      chk8("reset_pad_o", pad_o1, 8'h00);
      chk1("reset_req_ready", b1.req_ready, 1'b0);
      chk1("reset_rsp_valid", b1.rsp_valid, 1'b0);
      chk8("reset_rsp_data", b1.rsp_data, 8'h00);
      repeat (2) tick();
      chk1("in_reset_req_ready", b1.req_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      chk1("post_reset_req_ready", b1.req_ready, 1'b1);

      // Write 0xA5 from released bus: one dead cycle
      send1(1'b1, 8'hA5); wq.push_back(8'hA5);
      chk1("wa5_e0_oe", pad_oe1, 1'b0);
      chk1("wa5_e0_ready", b1.req_ready, 1'b0);
      tick();
      chk1("wa5_e1_oe", pad_oe1, 1'b0);
      chk1("wa5_e1_ready", b1.req_ready, 1'b0);
      tick();
      e = wq.pop_front();
      chk1("wa5_e2_oe", pad_oe1, 1'b1);
      chk8("wa5_e2_pad_o", pad_o1, e);
      chk1("wa5_e2_ready", b1.req_ready, 1'b1);

      // Back-to-back write, same direction
      send1(1'b1, 8'h3C); wq.push_back(8'h3C);
      chk1("w3c_e0_oe_parked", pad_oe1, 1'b1);
      chk8("w3c_e0_pad_o_parked", pad_o1, 8'hA5);
      tick();
      e = wq.pop_front();
      chk1("w3c_e1_oe", pad_oe1, 1'b1);
      chk8("w3c_e1_pad_o", pad_o1, e);

      // Read from driving bus, response back-pressured, write queued behind it
      pad_i1 = 8'h5A;
      b1.rsp_ready = 1'b0;
      send1(1'b0, 8'h00); rq.push_back(8'h5A);
      b1.req_valid = 1'b1; b1.req_write = 1'b1; b1.req_data = 8'h77;
      chk1("r5a_e0_oe", pad_oe1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk1("r5a_early_rsp_valid", b1.rsp_valid, 1'b0);
      end
      tick();
      e = rq.pop_front();
      chk1("r5a_e4_rsp_valid", b1.rsp_valid, 1'b1);
      chk8("r5a_e4_rsp_data", b1.rsp_data, e);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("hold_rsp_valid", b1.rsp_valid, 1'b1);
         chk8("hold_rsp_data", b1.rsp_data, e);
         chk1("hold_req_ready", b1.req_ready, 1'b0);
      end
      b1.rsp_ready = 1'b1;
      tick();
      b1.rsp_ready = 1'b0;
      chk1("rsp_hs_valid", b1.rsp_valid, 1'b0);
      chk1("rsp_hs_req_ready", b1.req_ready, 1'b1);
      tick();
      wq.push_back(8'h77);
      b1.req_valid = 1'b0;
      chk1("w77_accepted_ready", b1.req_ready, 1'b0);
      chk1("w77_e0_oe", pad_oe1, 1'b0);
      tick();
      chk1("w77_e1_oe", pad_oe1, 1'b0);
      tick();
      e = wq.pop_front();
      chk1("w77_e2_oe", pad_oe1, 1'b1);
      chk8("w77_e2_pad_o", pad_o1, e);

      // Asynchronous reset while in DRIVE
      send1(1'b1, 8'h11); wq.push_back(8'h11);
      chk1("w11_parked_oe", pad_oe1, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk1("rst_drive_oe", pad_oe1, 1'b0);
      chk8("rst_drive_pad_o", pad_o1, 8'h00);
      chk1("rst_drive_rsp_valid", b1.rsp_valid, 1'b0);
      wq.delete();
      #2 rst_n = 1'b1;
      tick();
      send1(1'b1, 8'h22); wq.push_back(8'h22);
      chk1("w22_e0_oe", pad_oe1, 1'b0);
      tick();
      chk1("w22_e1_oe", pad_oe1, 1'b0);
      tick();
      e = wq.pop_front();
      chk1("w22_e2_oe", pad_oe1, 1'b1);
      chk8("w22_e2_pad_o", pad_o1, e);

      // Read from driving bus with consumer ready
      pad_i1 = 8'hC3;
      b1.rsp_ready = 1'b1;
      send1(1'b0, 8'h00); rq.push_back(8'hC3);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk1("rc3_early_rsp_valid", b1.rsp_valid, 1'b0);
      end
      tick();
      e = rq.pop_front();
      chk1("rc3_e4_rsp_valid", b1.rsp_valid, 1'b1);
      chk8("rc3_e4_rsp_data", b1.rsp_data, e);
      tick();
      chk1("rc3_done", b1.rsp_valid, 1'b0);

      // Read with bus already released
      pad_i1 = 8'h96;
      send1(1'b0, 8'h00); rq.push_back(8'h96);
      for (int i = 1; i <= 2; i++) begin
         tick();
         chk1("r96_early_rsp_valid", b1.rsp_valid, 1'b0);
      end
      tick();
      e = rq.pop_front();
      chk1("r96_e3_rsp_valid", b1.rsp_valid, 1'b1);
      chk8("r96_e3_rsp_data", b1.rsp_data, e);
      tick();
      b1.rsp_ready = 1'b0;
      chk1("r96_done", b1.rsp_valid, 1'b0);

      // Asynchronous reset while in TURN: write is discarded
      send1(1'b1, 8'h44); wq.push_back(8'h44);
      chk1("w44_e0_oe", pad_oe1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk1("rst_turn_oe", pad_oe1, 1'b0);
      chk1("rst_turn_rsp_valid", b1.rsp_valid, 1'b0);
      wq.delete();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("w44_discard_oe", pad_oe1, 1'b0);
         chk8("w44_discard_pad_o", pad_o1, 8'h00);
      end
      send1(1'b1, 8'h55); wq.push_back(8'h55);
      tick();
      chk1("w55_e1_oe", pad_oe1, 1'b0);
      tick();
      e = wq.pop_front();
      chk1("w55_e2_oe", pad_oe1, 1'b1);
      chk8("w55_e2_pad_o", pad_o1, e);

      // TURN=0 instance: write then read
      chk1("dut0_ready", b0.req_ready, 1'b1);
      b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_data = 8'h81;
      tick();
      b0.req_valid = 1'b0;
      wq.push_back(8'h81);
      chk1("d0_w81_e0_oe", pad_oe0, 1'b0);
      tick();
      e = wq.pop_front();
      chk1("d0_w81_e1_oe", pad_oe0, 1'b1);
      chk8("d0_w81_e1_pad_o", pad_o0, e);
      pad_i0 = 8'h18;
      b0.rsp_ready = 1'b1;
      chk1("dut0_ready_rd", b0.req_ready, 1'b1);
      b0.req_valid = 1'b1; b0.req_write = 1'b0;
      tick();
      b0.req_valid = 1'b0;
      rq.push_back(8'h18);
      chk1("d0_r18_e0_oe", pad_oe0, 1'b0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         chk1("d0_r18_early_rsp_valid", b0.rsp_valid, 1'b0);
      end
      tick();
      e = rq.pop_front();
      chk1("d0_r18_e3_rsp_valid", b0.rsp_valid, 1'b1);
      chk8("d0_r18_e3_rsp_data", b0.rsp_data, e);
      tick();
      chk1("d0_r18_done", b0.rsp_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
